inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; legal values are powers of 2 that are at least max(ENQ_W,DEQ_W).
REQ-002 SHALL have parameter ENQ_W, default 2, meaning enqueue lanes per cycle.
REQ-003 SHALL have parameter DEQ_W, default 2, meaning dequeue lanes per cycle.
REQ-004 SHALL have parameter ID_W, default 20, meaning width of the dynamic id; it equals the di_t id field width.
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 flush_i  in  1  discard all entries.
REQ-008 enq_valid_i  in  ENQ_W  per-lane enqueue request.
REQ-009 enq_si_i  in  ENQ_W x si_t  static instructions, lane 0 oldest.
REQ-010 enq_ready_o  out  1  all lanes may enqueue this cycle.
REQ-011 deq_valid_o  out  DEQ_W  lane i holds the i-th oldest entry.
REQ-012 deq_di_o  out  DEQ_W x di_t  dynamic instructions.
REQ-013 deq_ready_i  in  DEQ_W  per-lane consumer accept.
REQ-014 count_o  out  clog2(DEPTH)+1  occupied entries.
REQ-015 next_id_o  out  ID_W  id the next enqueued instruction will receive.

Function
REQ-016 The enqueue valid mask SHALL be a contiguous prefix starting at lane 0; any other mask is illegal and is flagged by an assertion.
REQ-017 The dequeue ready mask SHALL be treated as a prefix: lane i is consumed only if deq_valid_o[i] and deq_ready_i[0..i] are all 1.
REQ-018 enq_ready_o SHALL be 1 when (DEPTH - count_o) >= ENQ_W, computed from registered count only.
REQ-019 Dequeues in the same cycle SHALL NOT raise enq_ready_o.
REQ-020 When enq_ready_o is 1 and k lanes are valid, the k entries SHALL be written in lane order at the tail.
REQ-021 When enq_ready_o is 0, enqueue requests SHALL be ignored and no state changes.
REQ-022 The stored di_t for each enqueued lane SHALL be: si = enq_si_i[lane]; id = next_id + lane; fault = ~enq_si_i[lane].valid; valid = 0.
REQ-023 On an accepted enqueue of k lanes, next_id SHALL advance by k, modulo 2^ID_W (wraps silently).
REQ-024 deq_valid_o[i] SHALL be 1 iff i < count_o; deq_di_o[i] is the entry at head+i; invalid lanes output 0.
REQ-025 Outputs SHALL be driven from registers and pointers with no combinational path from enq_* to deq_*.
REQ-026 Enqueue-to-dequeue latency SHALL be 1 cycle: an entry written at edge t is visible after edge t.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-028 count_o SHALL update as count + enq_accepted - deq_accepted each cycle, staying within 0..DEPTH.
REQ-029 Simultaneous enqueue and dequeue SHALL both take effect, including when count_o == DEPTH with ENQ_W = 0 accepted.
REQ-030 flush_i SHALL have priority over everything else: the next state is count 0 and head = tail.
REQ-031 Enqueues and dequeues presented in a flush cycle SHALL be discarded.
REQ-032 Flush SHALL NOT alter next_id.
REQ-033 Dequeue in a flush cycle SHALL NOT be considered accepted; the consumer must ignore it.

Reset
REQ-034 While rst_i is 1 (asynchronously), the block SHALL hold: count_o=0, head=tail=0, next_id_o=0, deq_valid_o=0, deq_di_o=0, enq_ready_o=1.
REQ-035 Entry storage SHALL need no reset.
REQ-036 Reset asserted mid-operation SHALL drop all entries immediately, with no partial update on the next edge.

Verification
REQ-037 Bench SHALL cover: after reset, enqueue 2 lanes (pc 0x100 valid=1, pc 0x104 valid=0) -> next cycle deq_valid_o=2'b11, ids 0 and 1, fault 0 and 1, next_id_o=2, count_o=2.
REQ-038 Bench SHALL cover: fill to count 7 with no dequeue -> enq_ready_o=0; a 2-lane request is ignored and count stays 7.
REQ-039 Bench SHALL cover: count 6, enqueue 2 and dequeue 2 in one cycle -> count 6; head advances by 2 and wraps correctly past index 7.
REQ-040 Bench SHALL cover: count 5, deq_ready_i=2'b10 -> nothing consumed; deq_ready_i=2'b01 -> exactly 1 consumed.
REQ-041 Bench SHALL cover: next_id 0xFFFFF, enqueue 2 -> ids 0xFFFFF and 0x00000, next_id_o=1.
REQ-042 Bench SHALL cover: count 4 with flush_i and a simultaneous 2-lane enqueue -> next cycle count 0, deq_valid_o=0, next_id_o unchanged; assert rst_i mid-traffic -> outputs zero immediately, before the next edge.

Source files
------------

// File: rtl/inst_queue.sv
// Multi-lane in-order instruction queue: enqueues up to ENQ_W static instructions per
// cycle, tags each with a sequential id and exposes the DEQ_W oldest entries.
package inst_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        valid;
  } si_t;

  typedef struct packed {
    si_t         si;
    logic [19:0] id;
    logic        fault;
    logic        valid;
  } di_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  parameter int ID_W  = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [ENQ_W-1:0]           enq_valid_i,
  input  si_t                        enq_si_i [ENQ_W],
  output logic                       enq_ready_o,
  output logic [DEQ_W-1:0]           deq_valid_o,
  output di_t                        deq_di_o [DEQ_W],
  input  logic [DEQ_W-1:0]           deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [ID_W-1:0]            next_id_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - ENQ_W);

  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [ID_W-1:0] next_id_reg;

  di_t             mem [DEPTH];
  di_t             enq_di [ENQ_W];
  logic [DEQ_W-1:0] deq_fire;
  logic            enq_fire;
  logic [CW-1:0]   enq_acc;
  logic [CW-1:0]   deq_num;

  // Readiness looks only at the registered count, so same-cycle dequeues never help.
  assign enq_ready_o = (count_reg <= ENQ_LIMIT);
  assign enq_fire    = enq_ready_o & ~flush_i;
  assign count_o     = count_reg;
  assign next_id_o   = next_id_reg;

  genvar gi;
  generate
    for (gi = 0; gi < ENQ_W; gi++) begin : g_enq
      assign enq_di[gi] = '{si:    enq_si_i[gi],
                            id:    next_id_reg + ID_W'(gi),
                            fault: ~enq_si_i[gi].valid,
                            valid: 1'b0};
    end

    for (gi = 0; gi < DEQ_W; gi++) begin : g_deq
      assign deq_valid_o[gi] = (CW'(gi) < count_reg);
      assign deq_di_o[gi]    = deq_valid_o[gi] ? mem[head_reg + PW'(gi)] : '0;
      // A lane is taken only when every older lane is also taken.
      assign deq_fire[gi]    = deq_valid_o[gi] & (&deq_ready_i[gi:0]);
    end
  endgenerate

  always_comb begin
    enq_acc = '0;
    deq_num = '0;
    if (enq_fire) begin
      for (int l = 0; l < ENQ_W; l++) begin
        enq_acc = enq_acc + CW'(enq_valid_i[l]);
      end
    end
    for (int i = 0; i < DEQ_W; i++) begin
      deq_num = deq_num + CW'(deq_fire[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      for (int l = 0; l < ENQ_W; l++) begin
        if (enq_valid_i[l]) begin
          mem[tail_reg + PW'(l)] <= enq_di[l];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      next_id_reg <= '0;
    end else if (flush_i) begin
      head_reg    <= tail_reg;
      count_reg   <= '0;
    end else begin
      head_reg    <= head_reg + PW'(deq_num);
      tail_reg    <= tail_reg + PW'(enq_acc);
      count_reg   <= count_reg + enq_acc - deq_num;
      next_id_reg <= next_id_reg + ID_W'(enq_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((enq_valid_i & (enq_valid_i + ENQ_W'(1))) == '0)
        else $error("inst_queue: enq_valid_i is not a prefix mask");
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, multi-cycle corner sequences and a
// randomized run, all scored against a queue-based behavioural model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int ID_W  = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [ENQ_W-1:0] enq_valid = '0;
  si_t              enq_si [ENQ_W];
  logic             enq_ready;
  logic [DEQ_W-1:0] deq_valid;
  di_t              deq_di [DEQ_W];
  logic [DEQ_W-1:0] deq_ready = '0;
  logic [3:0]       count;
  logic [ID_W-1:0]  next_id;

  inst_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_si_i(enq_si), .enq_ready_o(enq_ready),
    .deq_valid_o(deq_valid), .deq_di_o(deq_di), .deq_ready_i(deq_ready),
    .count_o(count), .next_id_o(next_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO of dynamic instructions plus an id counter.
  di_t             mq [$];
  logic [ID_W-1:0] mid;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  nd;
    int  k;
    bit  ready;
    di_t e;
    if (flush) begin
      mq.delete();
      return;
    end
    nd = 0;
    for (int i = 0; i < DEQ_W; i++) begin
      if (i < mq.size() && deq_ready[i]) nd++;
      else break;
    end
    k = 0;
    for (int l = 0; l < ENQ_W; l++) if (enq_valid[l]) k++;
    ready = ((DEPTH - mq.size()) >= ENQ_W);
    repeat (nd) void'(mq.pop_front());
    if (ready) begin
      for (int l = 0; l < k; l++) begin
        e.si    = enq_si[l];
        e.id    = mid + ID_W'(l);
        e.fault = ~enq_si[l].valid;
        e.valid = 1'b0;
        mq.push_back(e);
      end
      mid = mid + ID_W'(k);
    end
  endtask

  task automatic check_all(input string tag);
    di_t exp_di;
    cmp({tag, " count"}, count, mq.size());
    cmp({tag, " enq_ready"}, enq_ready, (DEPTH - mq.size()) >= ENQ_W);
    cmp({tag, " next_id"}, next_id, mid);
    for (int i = 0; i < DEQ_W; i++) begin
      exp_di = (i < mq.size()) ? mq[i] : '0;
      cmp($sformatf("%s deq_valid[%0d]", tag, i), deq_valid[i], i < mq.size());
      cmp($sformatf("%s deq_di[%0d]", tag, i), deq_di[i], exp_di);
    end
  endtask

  task automatic drive(input logic f, input logic [1:0] ev, input logic [1:0] dr,
                       input logic [31:0] pc0, input logic v0,
                       input logic [31:0] pc1, input logic v1);
    flush     = f;
    enq_valid = ev;
    deq_ready = dr;
    enq_si[0] = '{pc: pc0, insn: pc0 ^ 32'h1357_0000, valid: v0};
    enq_si[1] = '{pc: pc1, insn: pc1 ^ 32'h2468_0000, valid: v1};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mid = '0;
    cmp("reset count", count, 0);
    cmp("reset enq_ready", enq_ready, 1);
    cmp("reset deq_valid", deq_valid, 0);
    cmp("reset next_id", next_id, 0);
  endtask

  typedef struct {
    logic        f;
    logic [1:0]  ev;
    logic [31:0] pc0;
    logic        v0;
    logic [31:0] pc1;
    logic        v1;
    logic [1:0]  dr;
    int          exp_count;
    logic [1:0]  exp_dv;
    logic [19:0] exp_nid;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [1:0] ev_r;
    vt[0] = '{1'b0, 2'b11, 32'h100, 1'b1, 32'h104, 1'b0, 2'b00, 2, 2'b11, 20'd2};
    vt[1] = '{1'b0, 2'b01, 32'h108, 1'b1, 32'h0,   1'b0, 2'b00, 3, 2'b11, 20'd3};
    vt[2] = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b0, 2'b01, 2, 2'b11, 20'd3};
    vt[3] = '{1'b0, 2'b11, 32'h200, 1'b0, 32'h204, 1'b1, 2'b11, 2, 2'b11, 20'd5};
    vt[4] = '{1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b0, 2'b11, 0, 2'b00, 20'd5};
    vt[5] = '{1'b0, 2'b01, 32'h300, 1'b1, 32'h0,   1'b0, 2'b11, 1, 2'b01, 20'd6};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].f, vt[i].ev, vt[i].dr, vt[i].pc0, vt[i].v0, vt[i].pc1, vt[i].v1);
      cycle();
      cmp($sformatf("vec%0d count", i), count, vt[i].exp_count);
      cmp($sformatf("vec%0d deq_valid", i), deq_valid, vt[i].exp_dv);
      cmp($sformatf("vec%0d next_id", i), next_id, vt[i].exp_nid);
      check_all($sformatf("vec%0d", i));
      if (i == 0) begin
        cmp("first id0", deq_di[0].id, 20'd0);
        cmp("first fault0", deq_di[0].fault, 1'b0);
        cmp("first pc0", deq_di[0].si.pc, 32'h100);
        cmp("first id1", deq_di[1].id, 20'd1);
        cmp("first fault1", deq_di[1].fault, 1'b1);
        cmp("first pc1", deq_di[1].si.pc, 32'h104);
        cmp("first dvalid1", deq_di[1].valid, 1'b0);
      end
    end

    // Fill to 7, then a 2-lane request must be ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, 2'b00, 32'h400 + 32'(8 * i), 1'b1, 32'h404 + 32'(8 * i), 1'b1);
      cycle();
    end
    drive(1'b0, 2'b01, 2'b00, 32'h418, 1'b1, 32'h0, 1'b0);
    cycle();
    cmp("fill count", count, 7);
    cmp("fill enq_ready", enq_ready, 0);
    drive(1'b0, 2'b11, 2'b00, 32'h500, 1'b1, 32'h504, 1'b1);
    cycle();
    cmp("full ignore count", count, 7);
    cmp("full ignore next_id", next_id, 20'd7);
    check_all("full");

    // Count 6 with simultaneous enq2/deq2; head walks past index 7.
    drive(1'b0, 2'b00, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle();
    cmp("to6 count", count, 6);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 2'b11, 32'h600 + 32'(8 * i), 1'b1, 32'h604 + 32'(8 * i), 1'b0);
      cycle();
      cmp($sformatf("wrap%0d count", i), count, 6);
      check_all($sformatf("wrap%0d", i));
    end
    cmp("wrap head id", deq_di[0].id, 20'd9);

    // Prefix semantics of deq_ready.
    drive(1'b0, 2'b00, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle();
    cmp("to5 count", count, 5);
    drive(1'b0, 2'b00, 2'b10, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle();
    cmp("ready10 count", count, 5);
    drive(1'b0, 2'b00, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle();
    cmp("ready01 count", count, 4);
    check_all("prefix");

    // Flush with a simultaneous enqueue and dequeue.
    drive(1'b1, 2'b11, 2'b11, 32'h700, 1'b1, 32'h704, 1'b1);
    cycle();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
    cmp("flush count", count, 0);
    cmp("flush deq_valid", deq_valid, 2'b00);
    cmp("flush next_id", next_id, 20'd15);
    check_all("flush");

    // Id wrap-around from the top of the id space.
    do_reset();
    force dut.next_id_reg = 20'hFFFFF;
    #1;
    release dut.next_id_reg;
    mid = 20'hFFFFF;
    cmp("preset next_id", next_id, 20'hFFFFF);
    drive(1'b0, 2'b11, 2'b00, 32'h800, 1'b1, 32'h804, 1'b1);
    cycle();
    cmp("idwrap id0", deq_di[0].id, 20'hFFFFF);
    cmp("idwrap id1", deq_di[1].id, 20'h00000);
    cmp("idwrap next_id", next_id, 20'd1);
    check_all("idwrap");

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ev_r = 2'($urandom_range(0, 2));
      ev_r = (ev_r == 2'd2) ? 2'b11 : ev_r;
      drive(($urandom_range(0, 19) == 0), ev_r, 2'($urandom),
            $urandom, 1'($urandom), $urandom, 1'($urandom));
      cycle();
      check_all($sformatf("rnd%0d", c));
    end

    // Asynchronous reset in the middle of traffic.
    drive(1'b0, 2'b11, 2'b01, 32'h900, 1'b1, 32'h904, 1'b1);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    cmp("async rst count", count, 0);
    cmp("async rst deq_valid", deq_valid, 2'b00);
    cmp("async rst deq_di0", deq_di[0], '0);
    cmp("async rst enq_ready", enq_ready, 1);
    cmp("async rst next_id", next_id, 0);
    @(posedge clk);
    #1;
    cmp("held rst count", count, 0);
    cmp("held rst next_id", next_id, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
